// File: rtl/mult_result_buffer_pkg.sv
// Shared definitions for the multiplier completion buffer: tag width,
// multiplier pipeline depth and the buffered result record.
package mult_result_buffer_pkg;

  localparam int ROB_TAG_LEN = 6;
  localparam int NUM_STAGE   = 8;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] tag;
    logic [63:0]            value;
  } mult_result_t;

endpackage

// File: rtl/mult_result_buffer_result_fifo.sv
// In-order result storage with wrapping pointers, occupancy count and a
// synchronous clear that wins over enqueue/dequeue in the same cycle.
module result_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       enq,
  input  T                           enq_data,
  input  logic                       deq,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  T              mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  assign head = mem[head_ptr];

  // Storage is reset too so the head reads as zero out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        mem[tail_ptr] <= enq_data;
        tail_ptr      <= tail_ptr + PTR_ONE;
      end
      if (deq) head_ptr <= head_ptr + PTR_ONE;
      case ({enq, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult_result_buffer.sv
// Completion buffer between the non-stalling multiplier and the CDB arbiter:
// issues credits, buffers results in order and discards squashed work.
module mult_result_buffer
  import mult_result_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int N_STAGE = NUM_STAGE
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic                       mult_done,
  input  logic [63:0]                mult_product,
  input  logic [ROB_TAG_LEN-1:0]     mult_tag,
  output logic                       cdb_req,
  output logic [63:0]                cdb_value,
  output logic [ROB_TAG_LEN-1:0]     cdb_tag,
  input  logic                       cdb_grant,
  input  logic                       squash,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  // Handshake: a result moves to the CDB on any cycle where cdb_req and
  // cdb_grant are both high; issue_valid is only legal while issue_ready.
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(N_STAGE+2);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [IW-1:0] inflight;
  logic [IW-1:0] drop;
  logic [IW-1:0] inflight_next;
  logic [SW-1:0] credits_used;
  logic          dropping;
  logic          enq;
  logic          deq;
  mult_result_t  enq_data;
  mult_result_t  head;

  assign inflight_next = inflight + IW'(issue_valid) - IW'(mult_done);
  assign dropping      = mult_done && (drop != '0);
  assign enq           = mult_done && !dropping && !squash;
  assign deq           = cdb_req && cdb_grant && !squash;
  assign enq_data      = '{tag: mult_tag, value: mult_product};

  assign credits_used = SW'(count) + SW'(inflight);
  assign issue_ready  = credits_used < SW'(DEPTH);

  assign cdb_req   = (count != '0);
  assign cdb_value = head.value;
  assign cdb_tag   = head.tag;

  // Ops issued in the squash cycle are still counted in inflight_next,
  // so they are discarded along with everything else in the pipe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_next;
      if (squash)        drop <= inflight_next;
      else if (dropping) drop <= drop - IW'(1);
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .T     (mult_result_t)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (squash),
    .enq      (enq),
    .enq_data (enq_data),
    .deq      (deq),
    .head     (head),
    .count    (count)
  );

  a_issue_credit: assert property (@(posedge clock) disable iff (!reset)
    issue_valid |-> issue_ready);
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    (enq && (count == CW'(DEPTH))) |-> deq);
  a_done_inflight: assert property (@(posedge clock) disable iff (!reset)
    mult_done |-> (inflight != '0));
  a_drop_bound: assert property (@(posedge clock) disable iff (!reset)
    drop <= inflight);

endmodule

// File: tb/tb_mult_result_buffer.sv
// Directed bench for mult_result_buffer: a DEPTH=4 instance for credit and
// reset behaviour and a DEPTH=16 instance for streaming and squash cases.
module tb_mult_result_buffer;
  import mult_result_buffer_pkg::*;

  localparam int NS = 8;

  logic                   clock;
  logic                   reset;
  logic                   issue_valid_a, issue_valid_s;
  logic [ROB_TAG_LEN-1:0] issue_tag;
  logic [31:0]            op_a, op_b;
  logic                   grant, squash;

  logic                   issue_ready_a, issue_ready_s;
  logic                   mult_done_a, mult_done_s;
  logic [63:0]            mult_product;
  logic [ROB_TAG_LEN-1:0] mult_tag;
  logic                   cdb_req_a, cdb_req_s;
  logic [63:0]            cdb_value_a, cdb_value_s;
  logic [ROB_TAG_LEN-1:0] cdb_tag_a, cdb_tag_s;
  logic [2:0]             count_a;
  logic [4:0]             count_s;

  logic [ROB_TAG_LEN-1:0] exp_q[$];
  int checks;
  int failures;

  mult_result_buffer #(.DEPTH(4), .N_STAGE(NS)) dut_a (
    .clock(clock), .reset(reset), .issue_valid(issue_valid_a),
    .issue_ready(issue_ready_a), .mult_done(mult_done_a),
    .mult_product(mult_product), .mult_tag(mult_tag), .cdb_req(cdb_req_a),
    .cdb_value(cdb_value_a), .cdb_tag(cdb_tag_a), .cdb_grant(grant),
    .squash(squash), .count(count_a)
  );

  mult_result_buffer #(.DEPTH(16), .N_STAGE(NS)) dut_s (
    .clock(clock), .reset(reset), .issue_valid(issue_valid_s),
    .issue_ready(issue_ready_s), .mult_done(mult_done_s),
    .mult_product(mult_product), .mult_tag(mult_tag), .cdb_req(cdb_req_s),
    .cdb_value(cdb_value_s), .cdb_tag(cdb_tag_s), .cdb_grant(grant),
    .squash(squash), .count(count_s)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Multiplier model: fixed NS-cycle pipe; data shared, valid per instance.
  logic [NS-1:0]          pv_a, pv_s;
  logic [ROB_TAG_LEN-1:0] ptag  [NS];
  logic [63:0]            pprod [NS];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pv_a <= '0;
      pv_s <= '0;
    end else begin
      pv_a     <= {pv_a[NS-2:0], issue_valid_a};
      pv_s     <= {pv_s[NS-2:0], issue_valid_s};
      ptag[0]  <= issue_tag;
      pprod[0] <= 64'(op_a) * 64'(op_b);
      for (int k = 1; k < NS; k++) begin
        ptag[k]  <= ptag[k-1];
        pprod[k] <= pprod[k-1];
      end
    end
  end

  assign mult_done_a  = pv_a[NS-1];
  assign mult_done_s  = pv_s[NS-1];
  assign mult_product = pprod[NS-1];
  assign mult_tag     = ptag[NS-1];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    issue_valid_a = 1'b0;
    issue_valid_s = 1'b0;
    issue_tag     = '0;
    op_a          = '0;
    op_b          = '0;
    grant         = 1'b0;
    squash        = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) tick();
    checks++; if (cdb_req_a !== 1'b0) begin failures++; $display("FAIL reset_req: got %0d expected 0", cdb_req_a); end
    checks++; if (count_a !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count_a); end
    checks++; if (issue_ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0d expected 1", issue_ready_a); end
    checks++; if (cdb_value_a !== 64'd0) begin failures++; $display("FAIL reset_value: got %0d expected 0", cdb_value_a); end
    checks++; if (cdb_tag_a !== '0) begin failures++; $display("FAIL reset_tag: got %0d expected 0", cdb_tag_a); end
    reset = 1'b1;
    tick();
    checks++; if (issue_ready_s !== 1'b1 || cdb_req_s !== 1'b0) begin failures++; $display("FAIL reset_wide: got ready=%0d req=%0d expected 1 0", issue_ready_s, cdb_req_s); end
  endtask

  task automatic test_single_op();
    issue_valid_a = 1'b1; issue_tag = 5; op_a = 3; op_b = 5;
    tick();
    issue_valid_a = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (cdb_req_a !== 1'b0) begin failures++; $display("FAIL single_early_req: cycle %0d got %0d expected 0", c, cdb_req_a); end
      tick();
    end
    checks++; if (cdb_req_a !== 1'b1) begin failures++; $display("FAIL single_req: got %0d expected 1", cdb_req_a); end
    checks++; if (cdb_value_a !== 64'd15) begin failures++; $display("FAIL single_value: got %0d expected 15", cdb_value_a); end
    checks++; if (cdb_tag_a !== 6'd5) begin failures++; $display("FAIL single_tag: got %0d expected 5", cdb_tag_a); end
    grant = 1'b1;
    tick();
    grant = 1'b0;
    checks++; if (cdb_req_a !== 1'b0 || count_a !== 3'd0) begin failures++; $display("FAIL single_pop: got req=%0d count=%0d expected 0 0", cdb_req_a, count_a); end
  endtask

  task automatic test_credit();
    for (int i = 0; i < 4; i++) begin
      checks++; if (issue_ready_a !== 1'b1) begin failures++; $display("FAIL credit_ready: issue %0d got %0d expected 1", i, issue_ready_a); end
      issue_valid_a = 1'b1; issue_tag = 6'(10 + i); op_a = 32'(i + 1); op_b = 100;
      tick();
    end
    issue_valid_a = 1'b0;
    for (int c = 4; c < 14; c++) begin
      checks++; if (issue_ready_a !== 1'b0) begin failures++; $display("FAIL credit_exhausted: cycle %0d got %0d expected 0", c, issue_ready_a); end
      tick();
    end
    checks++; if (count_a !== 3'd4) begin failures++; $display("FAIL credit_full_count: got %0d expected 4", count_a); end
    checks++; if (cdb_tag_a !== 6'd10) begin failures++; $display("FAIL credit_head_tag: got %0d expected 10", cdb_tag_a); end
    grant = 1'b1;
    tick();
    checks++; if (issue_ready_a !== 1'b1) begin failures++; $display("FAIL credit_freed: got %0d expected 1", issue_ready_a); end
    checks++; if (count_a !== 3'd3) begin failures++; $display("FAIL credit_after_pop: got %0d expected 3", count_a); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (cdb_tag_a !== 6'(10 + i) || cdb_value_a !== 64'((i + 1) * 100)) begin
        failures++; $display("FAIL credit_drain: got tag=%0d value=%0d expected %0d %0d", cdb_tag_a, cdb_value_a, 10 + i, (i + 1) * 100);
      end
      tick();
    end
    grant = 1'b0;
    checks++; if (count_a !== 3'd0 || cdb_req_a !== 1'b0) begin failures++; $display("FAIL credit_empty: got count=%0d req=%0d expected 0 0", count_a, cdb_req_a); end
  endtask

  task automatic test_streaming();
    logic                   exp_req;
    logic [ROB_TAG_LEN-1:0] exp_tag;
    grant = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c < 20) begin
        checks++; if (issue_ready_s !== 1'b1) begin failures++; $display("FAIL stream_ready: cycle %0d got %0d expected 1", c, issue_ready_s); end
        issue_valid_s = 1'b1; issue_tag = 6'(c); op_a = 32'(c); op_b = 3;
        exp_q.push_back(6'(c));
      end else begin
        issue_valid_s = 1'b0;
      end
      exp_req = (c >= 9) && (c < 29);
      checks++; if (cdb_req_s !== exp_req) begin failures++; $display("FAIL stream_req: cycle %0d got %0d expected %0d", c, cdb_req_s, exp_req); end
      if (exp_req && exp_q.size() > 0) begin
        exp_tag = exp_q.pop_front();
        checks++; if (cdb_tag_s !== exp_tag || cdb_value_s !== 64'(exp_tag) * 64'd3) begin
          failures++; $display("FAIL stream_data: cycle %0d got tag=%0d value=%0d expected %0d %0d", c, cdb_tag_s, cdb_value_s, exp_tag, exp_tag * 3);
        end
      end
      checks++; if (count_s > 5'd1) begin failures++; $display("FAIL stream_count: cycle %0d got %0d expected <=1", c, count_s); end
      tick();
    end
    grant = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_leftover: got %0d expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_squash();
    int exp_drop;
    for (int c = 0; c <= 10; c++) begin
      issue_valid_s = (c == 0) || (c == 1) || (c == 7) || (c == 8) || (c == 9);
      issue_tag = 6'(20 + c); op_a = 32'(20 + c); op_b = 1;
      squash = (c == 10);
      if (c == 10) begin
        checks++; if (count_s !== 5'd2) begin failures++; $display("FAIL squash_pre_count: got %0d expected 2", count_s); end
      end
      tick();
    end
    squash = 1'b0; issue_valid_s = 1'b0;
    checks++; if (count_s !== 5'd0) begin failures++; $display("FAIL squash_count: got %0d expected 0", count_s); end
    for (int c = 11; c < 20; c++) begin
      exp_drop = (c <= 15) ? 3 : (c == 16) ? 2 : (c == 17) ? 1 : 0;
      checks++; if (cdb_req_s !== 1'b0) begin failures++; $display("FAIL squash_stale_req: cycle %0d got %0d expected 0", c, cdb_req_s); end
      checks++; if (dut_s.drop !== 4'(exp_drop)) begin failures++; $display("FAIL squash_drop: cycle %0d got %0d expected %0d", c, dut_s.drop, exp_drop); end
      tick();
    end
    issue_valid_s = 1'b1; issue_tag = 9; op_a = 7; op_b = 6;
    tick();
    issue_valid_s = 1'b0;
    repeat (8) tick();
    checks++; if (cdb_req_s !== 1'b1 || cdb_tag_s !== 6'd9 || cdb_value_s !== 64'd42) begin
      failures++; $display("FAIL squash_resume: got req=%0d tag=%0d value=%0d expected 1 9 42", cdb_req_s, cdb_tag_s, cdb_value_s);
    end
    grant = 1'b1;
    tick();
    grant = 1'b0;
    checks++; if (cdb_req_s !== 1'b0) begin failures++; $display("FAIL squash_resume_pop: got %0d expected 0", cdb_req_s); end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c <= 10; c++) begin
      issue_valid_s = (c <= 2) || (c == 10);
      issue_tag = 6'(30 + c); op_a = 32'(30 + c); op_b = 2;
      squash = (c == 10);
      grant  = (c == 10);
      if (c == 10) begin
        checks++; if (count_s !== 5'd2) begin failures++; $display("FAIL simul_pre_count: got %0d expected 2", count_s); end
      end
      tick();
    end
    squash = 1'b0; grant = 1'b0; issue_valid_s = 1'b0;
    checks++; if (count_s !== 5'd0) begin failures++; $display("FAIL simul_count: got %0d expected 0", count_s); end
    checks++; if (dut_s.drop !== 4'd1) begin failures++; $display("FAIL simul_drop: got %0d expected 1", dut_s.drop); end
    for (int c = 11; c <= 20; c++) begin
      checks++; if (cdb_req_s !== 1'b0) begin failures++; $display("FAIL simul_stale_req: cycle %0d got %0d expected 0", c, cdb_req_s); end
      tick();
    end
    checks++; if (dut_s.drop !== 4'd0 || dut_s.inflight !== 4'd0) begin
      failures++; $display("FAIL simul_settled: got drop=%0d inflight=%0d expected 0 0", dut_s.drop, dut_s.inflight);
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c <= 11; c++) begin
      issue_valid_a = (c <= 2);
      issue_tag = 6'(40 + c); op_a = 32'(c + 1); op_b = 9;
      tick();
    end
    issue_valid_a = 1'b0;
    checks++; if (count_a !== 3'd3 || cdb_req_a !== 1'b1) begin failures++; $display("FAIL areset_pre: got count=%0d req=%0d expected 3 1", count_a, cdb_req_a); end
    #2 reset = 1'b0;
    #1;
    checks++; if (cdb_req_a !== 1'b0) begin failures++; $display("FAIL areset_req: got %0d expected 0", cdb_req_a); end
    checks++; if (count_a !== 3'd0) begin failures++; $display("FAIL areset_count: got %0d expected 0", count_a); end
    checks++; if (issue_ready_a !== 1'b1) begin failures++; $display("FAIL areset_ready: got %0d expected 1", issue_ready_a); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (count_a !== 3'd0 || cdb_req_a !== 1'b0) begin failures++; $display("FAIL areset_hold: got count=%0d req=%0d expected 0 0", count_a, cdb_req_a); end
    end
    reset = 1'b1;
    tick();
    checks++; if (count_a !== 3'd0 || issue_ready_a !== 1'b1) begin failures++; $display("FAIL areset_release: got count=%0d ready=%0d expected 0 1", count_a, issue_ready_a); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_op();
    test_credit();
    test_streaming();
    test_squash();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_result_buffer.md
# mult_result_buffer

Completion buffer between the pipelined multiplier functional unit and the CDB arbiter. The multiplier cannot stall, so this block gives the multiply reservation station issue credits. Credits count buffer occupancy plus operations in flight. The block captures every `done` result with its ROB tag and presents results in order to the CDB with a request/grant handshake. On branch squash it flushes buffered results and discards results still in the pipe.

## Interface
Parameters:
- `DEPTH`, 4: result entries; power of two, ≥2
- `N_STAGE`, `` `NUM_STAGE `` (8): multiplier pipeline depth; bounds the in-flight count

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `issue_valid`  in  1  RS starts a multiply this cycle; same signal drives multiplier `start`
- `issue_ready`  out  1  credit available; RS may assert `issue_valid` only when high
- `mult_done`  in  1  multiplier result valid
- `mult_product`  in  64  multiplier low-64 product
- `mult_tag`  in  `` `ROB_TAG_LEN ``  ROB tag of the result
- `cdb_req`  out  1  head entry valid, requesting the CDB
- `cdb_value`  out  64  head entry product
- `cdb_tag`  out  `` `ROB_TAG_LEN ``  head entry tag
- `cdb_grant`  in  1  arbiter accepts the head this cycle
- `squash`  in  1  mispredict flush
- `count`  out  $clog2(DEPTH+1)  buffered entries

## Operation
- Registered state:
  - FIFO of {tag, value}, with head/tail pointers that wrap mod DEPTH.
  - `count`.
  - `inflight`: width $clog2(N_STAGE+2); issued but not yet done.
  - `drop`: in-flight results to discard; `drop` ≤ `inflight`.
- `inflight_next = inflight + issue_valid − mult_done`.
- `issue_ready = (count + inflight) < DEPTH`. It is a function of registers only and ignores a same-cycle grant.
- On `mult_done`:
  - If `drop > 0` (current value), discard the result and decrement `drop`.
  - Otherwise enqueue at the tail.
- `cdb_req = (count != 0)`. `cdb_value` and `cdb_tag` come from the head entry.
  - A cycle with `cdb_req && cdb_grant` pops the head.
  - Grant without req is ignored.
- Enqueue and pop in the same cycle: `count` is unchanged and both pointers advance. This is legal at `count == DEPTH`.
- `squash` cycle:
  - Pointers and `count` clear.
  - Any grant or `mult_done` in that cycle is ignored, and that result is discarded.
  - `drop <= inflight_next`. An `issue_valid` in the squash cycle is a squashed-path op and is therefore dropped.
  - `squash` has priority over all other events.
- Illegal conditions (covered by assertions, not by RTL recovery):
  - `issue_valid` while `!issue_ready`. The RTL still counts the issue.
  - Enqueue with `count == DEPTH` and no pop.
  - `mult_done` with `inflight == 0`.
- Reset values:
  - `cdb_req` 0, `cdb_value` 0, `cdb_tag` 0, `count` 0.
  - `inflight` 0, `drop` 0, pointers 0.
  - `issue_ready` 1.

## Timing
- All outputs are valid from registers. No combinational path runs from `cdb_grant`, `mult_done` or `squash` to any output.
- Multiplier latency is N_STAGE cycles: an issue at cycle t gives `mult_done` at t+N_STAGE.
- An enqueue at edge e raises `cdb_req` after e. The earliest `cdb_req` is at t+N_STAGE+1.
- A pop at edge e updates the head and `count` after e.
- A credit freed by a pop or by a discarded drop shows on `issue_ready` the cycle after.
- Sustained throughput with `cdb_grant` tied high is 1 result/cycle, with no bubbles.
- Asynchronous reset forces all registers immediately, including in the middle of a drop sequence. In-flight multiplier results arriving after reset releases are illegal; the multiplier is reset in the same domain.

## Structure
- Shared package (`sys_defs.svh`):
  - `typedef struct packed { logic [`ROB_TAG_LEN-1:0] tag; logic [63:0] value; } mult_result_t;`
  - `` `NUM_STAGE ``
- Sub-module `result_fifo #(DEPTH, type T)`: storage, pointers, `count`, and a synchronous clear. The credit and drop counters stay in the top level.

## Test plan
1. Single op, N_STAGE=8, DEPTH=4:
   - Stimulus: after reset, issue tag 5 (3×5) at cycle 0.
   - Response: `mult_done` at cycle 8; at cycle 9 `cdb_req`=1, value 15, tag 5. Grant at 9 gives `cdb_req`=0 and `count`=0 at 10.
2. Credit exhaustion, `cdb_grant`=0:
   - Stimulus: issue every cycle.
   - Response: `issue_ready` falls after 4 issues and stays 0 after the results land (`count`=4). One grant makes `issue_ready`=1 on the next cycle.
3. Streaming:
   - Stimulus: grant tied high, 20 back-to-back issues with tags 0..19.
   - Response: 20 consecutive `cdb_req` cycles in tag order, with no gaps; `count` ≤1.
4. Squash with work in flight:
   - Stimulus: squash with 2 entries buffered and 3 in flight.
   - Response: `count`=0 next cycle and the 3 later results are discarded (`drop` counts 3→0). A subsequent issue of tag 9 is delivered normally.
5. Simultaneous events:
   - Stimulus: squash in the same cycle as `mult_done`, `cdb_grant` and `issue_valid`.
   - Response: the done is discarded, the grant has no effect, `drop` = `inflight`+1−1, and no stale result ever reaches the CDB.
6. Asynchronous reset mid-operation:
   - Stimulus: drive `reset` low between edges with `count`=3.
   - Response: immediately `cdb_req`=0, `count`=0, `issue_ready`=1, and the state stays reset until release.
